// File: rtl/ins_encoder.sv
// RV32I instruction encoder/loader: packs decoded fields into instruction words and
// streams them into instruction memory. Optional immediate range check: IMM_RANGE_CHECK_EN.
module ins_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    input  logic              mem_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic [ADDR_W:0]   count,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   LAST = {1'b0, {ADDR_W{1'b1}}};

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_SB   = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_AUI  = 7'b0010111;

    typedef enum logic [1:0] {IDLE, RUN, FULL} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [1:0]        err_code_q, err_code_d;

    logic [31:0]       enc_word;
    logic              enc_ok;
    logic              imm_bad;
    logic              accept;
    logic              complete;

    always_comb begin
        enc_word = '0;
        enc_ok   = 1'b1;
        case (opcode)
            OP_R:                    enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
            OP_IMM, OP_LOAD, OP_JALR: enc_word = {imm[11:0], rs1, funct3, rd, opcode};
            OP_S:                    enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            OP_SB:                   enc_word = {imm[12], imm[10:5], rs2, rs1, funct3,
                                                 imm[4:1], imm[11], opcode};
            OP_LUI, OP_AUI:          enc_word = {imm[31:12], rd, opcode};
            default:                 enc_ok   = 1'b0;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    always_comb begin
        imm_bad = 1'b0;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR, OP_S:
                imm_bad = !((&imm[31:11]) || !(|imm[31:11]));
            OP_SB:
                imm_bad = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
            OP_LUI, OP_AUI:
                imm_bad = |imm[11:0];
            default:
                imm_bad = 1'b0;
        endcase
    end
`else
    assign imm_bad = 1'b0;
`endif

    // The last free slot is reserved once it holds a pending write, so no
    // address is ever handed out twice before FULL takes effect.
    assign in_ready = (state_q == RUN) && !start && (!we_q || mem_ready)
                      && !(we_q && (count_q == LAST));
    assign accept   = in_valid && in_ready;
    assign complete = we_q && mem_ready;

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        count_d    = count_q;
        err_code_d = err_code_q;
        if (start) begin
            state_d    = RUN;
            we_d       = 1'b0;
            waddr_d    = BASE;
            count_d    = '0;
            err_code_d = '0;
        end else begin
            if (complete) begin
                we_d    = 1'b0;
                waddr_d = waddr_q + 1'b1;
                count_d = count_q + 1'b1;
                if (count_q == LAST) state_d = FULL;
            end
            if (accept) begin
                if (enc_ok) begin
                    we_d    = 1'b1;
                    wdata_d = enc_word;
                    if (imm_bad) err_code_d[1] = 1'b1;
                end else begin
                    err_code_d[0] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            waddr_q    <= BASE;
            wdata_q    <= '0;
            count_q    <= '0;
            err_code_q <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            count_q    <= count_d;
            err_code_q <= err_code_d;
        end
    end

    assign we       = we_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign count    = count_q;
    assign err_code = err_code_q;
    assign err      = |err_code_q;

endmodule
